// File: rtl/data_mem_arbiter_if.sv
// Signal bundle joining both bus masters and data_mem to data_mem_arbiter.
// The arbiter connects via the slave modport; the masters/memory side uses master.
interface data_mem_arbiter_if;
   logic        m0_req_i;
   logic        m0_we_i;
   logic [3:0]  m0_be_i;
   logic [31:0] m0_addr_i;
   logic [31:0] m0_wdata_i;
   logic [31:0] m0_rdata_o;
   logic        m0_ready_o;
   logic        m0_err_o;

   logic        m1_req_i;
   logic        m1_we_i;
   logic [3:0]  m1_be_i;
   logic [31:0] m1_addr_i;
   logic [31:0] m1_wdata_i;
   logic [31:0] m1_rdata_o;
   logic        m1_ready_o;
   logic        m1_err_o;

   logic        mem_req_o;
   logic        write_enable_o;
   logic [3:0]  byte_enable_o;
   logic [31:0] addr_o;
   logic [31:0] write_data_o;
   logic [31:0] read_data_i;
   logic        ready_i;

   modport slave (
      input  m0_req_i, m0_we_i, m0_be_i, m0_addr_i, m0_wdata_i,
      output m0_rdata_o, m0_ready_o, m0_err_o,
      input  m1_req_i, m1_we_i, m1_be_i, m1_addr_i, m1_wdata_i,
      output m1_rdata_o, m1_ready_o, m1_err_o,
      output mem_req_o, write_enable_o, byte_enable_o, addr_o, write_data_o,
      input  read_data_i, ready_i
   );

   modport master (
      output m0_req_i, m0_we_i, m0_be_i, m0_addr_i, m0_wdata_i,
      input  m0_rdata_o, m0_ready_o, m0_err_o,
      output m1_req_i, m1_we_i, m1_be_i, m1_addr_i, m1_wdata_i,
      input  m1_rdata_o, m1_ready_o, m1_err_o,
      input  mem_req_o, write_enable_o, byte_enable_o, addr_o, write_data_o,
      output read_data_i, ready_i
   );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter sharing single-port data_mem between the LSU (port 0) and a second master.
// Define DATA_MEM_ARB_FIXED_PRIO_EN for fixed port-0 priority instead of round-robin.
module data_mem_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input logic               clk_i,
   input logic               rst_ni,
   data_mem_arbiter_if.slave bus
);
   localparam int unsigned     CntW    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
   localparam logic [0:0]      StIdle  = 1'b0;
   localparam logic [0:0]      StBusy  = 1'b1;

   logic [0:0]      state_q, state_d;
   logic            owner_q, owner_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            we_q, we_d;
   logic [3:0]      be_q, be_d;
   logic [31:0]     addr_q, addr_d;
   logic [31:0]     wdata_q, wdata_d;
   logic            any_req, winner, timeout, done, mem_req;

   // Gated by reset so every output is quiet while reset is held, even with requests pending.
   assign any_req = rst_ni & (bus.m0_req_i | bus.m1_req_i);
   assign timeout = (cnt_q == CntLast);
   assign done    = (state_q == StBusy) & (bus.ready_i | timeout);

`ifdef DATA_MEM_ARB_FIXED_PRIO_EN
   assign winner = ~bus.m0_req_i;
`else
   logic ptr_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q <= 1'b0;
      end else if (done) begin
         ptr_q <= ~owner_q;
      end
   end

   assign winner = (bus.m0_req_i & bus.m1_req_i) ? ptr_q : bus.m1_req_i;
`endif

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      be_d    = be_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      mem_req = 1'b0;
      case (state_q)
         StIdle: begin
            if (any_req) begin
               mem_req = 1'b1;
               owner_d = winner;
               cnt_d   = '0;
               state_d = StBusy;
               we_d    = winner ? bus.m1_we_i    : bus.m0_we_i;
               be_d    = winner ? bus.m1_be_i    : bus.m0_be_i;
               addr_d  = winner ? bus.m1_addr_i  : bus.m0_addr_i;
               wdata_d = winner ? bus.m1_wdata_i : bus.m0_wdata_i;
            end
         end
         default: begin
            if (done) begin
               state_d = StIdle;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         owner_q <= 1'b0;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         be_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         be_q    <= be_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   // The _d values equal the winner's fields at a grant and the held _q values otherwise.
   assign bus.mem_req_o      = mem_req;
   assign bus.write_enable_o = we_d;
   assign bus.byte_enable_o  = be_d;
   assign bus.addr_o         = addr_d;
   assign bus.write_data_o   = wdata_d;

   assign bus.m0_ready_o = done & ~owner_q;
   assign bus.m1_ready_o = done & owner_q;
   assign bus.m0_err_o   = done & ~owner_q & ~bus.ready_i;
   assign bus.m1_err_o   = done & owner_q & ~bus.ready_i;
   assign bus.m0_rdata_o = (done & ~owner_q & bus.ready_i) ? bus.read_data_i : '0;
   assign bus.m1_rdata_o = (done & owner_q & bus.ready_i) ? bus.read_data_i : '0;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomized scoreboard bench for data_mem_arbiter with a byte-enabled data_mem model attached.
module tb_data_mem_arbiter;
   localparam int unsigned Timeout = 16;
   localparam int          Bound   = 400;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic        chk;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_ready;
   logic [31:0] rd_q;
   logic [31:0] dmem    [0:255];
   logic [31:0] ref_mem [0:255];
   exp_t        exp_q0[$];
   exp_t        exp_q1[$];
   int          done_log[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          last_grant_cyc = 0;
   logic [3:0]  last_be = '0;
   logic        last_we = 1'b0;

   data_mem_arbiter_if bus ();

   data_mem_arbiter #(.TIMEOUT_CYCLES(Timeout)) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus)
   );

   assign bus.ready_i     = mem_ready;
   assign bus.read_data_i = rd_q;

   always #5 clk = ~clk;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] be);
      logic [31:0] mask;
      mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      return (old & ~mask) | (nw & mask);
   endfunction

   // data_mem: commits writes at the grant edge, returns read data the following cycle
   always @(posedge clk) begin
      if (bus.mem_req_o) begin
         if (bus.write_enable_o) begin
            dmem[bus.addr_o[9:2]] <= merge(dmem[bus.addr_o[9:2]], bus.write_data_o,
                                           bus.byte_enable_o);
         end else begin
            rd_q <= dmem[bus.addr_o[9:2]];
         end
      end
   end

   function automatic logic port_ready(input int p);
      return (p == 0) ? bus.m0_ready_o : bus.m1_ready_o;
   endfunction

   function automatic logic port_err(input int p);
      return (p == 0) ? bus.m0_err_o : bus.m1_err_o;
   endfunction

   function automatic logic [31:0] port_rdata(input int p);
      return (p == 0) ? bus.m0_rdata_o : bus.m1_rdata_o;
   endfunction

   task automatic drive(input int p, input logic req, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata);
      if (p == 0) begin
         bus.m0_req_i = req; bus.m0_we_i = we; bus.m0_be_i = be;
         bus.m0_addr_i = addr; bus.m0_wdata_i = wdata;
      end else begin
         bus.m1_req_i = req; bus.m1_we_i = we; bus.m1_be_i = be;
         bus.m1_addr_i = addr; bus.m1_wdata_i = wdata;
      end
   endtask

   // Called just after a rising edge; returns just after the edge that ends the access.
   task automatic access(input int p, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic exp_err);
      exp_t e;
      int   n;
      logic got;
      e.rdata = '0;
      e.err   = exp_err;
      e.chk   = 1'b1;
      if (!exp_err) begin
         if (we) begin
            ref_mem[addr[9:2]] = merge(ref_mem[addr[9:2]], wdata, be);
            e.chk = 1'b0;
         end else begin
            e.rdata = ref_mem[addr[9:2]];
         end
      end
      if (p == 0) exp_q0.push_back(e);
      else exp_q1.push_back(e);
      drive(p, 1'b1, we, be, addr, wdata);
      n   = 0;
      got = 1'b0;
      while (!got && n < Bound) begin
         @(negedge clk);
         n++;
         got = port_ready(p);
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL wait_ready port %0d: ready=0 after %0d cycles, required 1", p, n);
      end
      @(posedge clk);
      #2;
      drive(p, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
   endtask

   task automatic rep_reads(input int p, input int n);
      for (int i = 0; i < n; i++) access(p, 1'b0, 4'hF, 32'((p * 16 + i) * 4), 32'h0, 1'b0);
   endtask

   task automatic rand_port(input int p, input int n);
      logic [31:0] r;
      logic [7:0]  w;
      logic        we;
      for (int i = 0; i < n; i++) begin
         r  = $urandom();
         w  = 8'(p * 16 + int'($urandom_range(0, 15)));
         we = 1'($urandom_range(0, 1));
         access(p, we, 4'($urandom_range(0, 15)), {r[31:10], w, 2'b00}, $urandom(), 1'b0);
      end
   endtask

   task automatic check_quiet(input string name);
      logic [137:0] v;
      v = {bus.mem_req_o, bus.write_enable_o, bus.byte_enable_o, bus.addr_o, bus.write_data_o,
           bus.m0_rdata_o, bus.m1_rdata_o, bus.m0_ready_o, bus.m1_ready_o, bus.m0_err_o,
           bus.m1_err_o};
      checks++;
      if (v != '0) begin
         errors++;
         $display("FAIL %s: outputs=%h, required all 0", name, v);
      end
   endtask

   task automatic check_resp(input int p);
      exp_t e;
      int   lat;
      int   exp_lat;
      checks++;
      if ((p == 0 && exp_q0.size() == 0) || (p == 1 && exp_q1.size() == 0)) begin
         errors++;
         $display("FAIL unexpected_ready port %0d: ready=1, required 0 (no access pending)", p);
      end else begin
         if (p == 0) e = exp_q0.pop_front();
         else e = exp_q1.pop_front();
         lat     = cyc - last_grant_cyc;
         exp_lat = e.err ? int'(Timeout) : 1;
         if (port_err(p) != e.err || (e.chk && port_rdata(p) != e.rdata) || lat != exp_lat) begin
            errors++;
            $display("FAIL resp port %0d: err=%0b rdata=%h latency=%0d, required err=%0b rdata=%h latency=%0d",
                     p, port_err(p), port_rdata(p), lat, e.err, e.rdata, exp_lat);
         end
         done_log.push_back(p);
      end
   endtask

   initial begin : monitor
      forever begin
         @(negedge clk);
         cyc++;
         if (bus.mem_req_o) begin
            last_grant_cyc = cyc;
            last_be        = bus.byte_enable_o;
            last_we        = bus.write_enable_o;
         end
         if (bus.m0_ready_o && bus.m1_ready_o) begin
            checks++;
            errors++;
            $display("FAIL both_ready: m0_ready=1 m1_ready=1, required at most one");
         end
         for (int p = 0; p < 2; p++) begin
            if (port_ready(p)) begin
               check_resp(p);
            end else begin
               checks++;
               if (port_err(p) || port_rdata(p) != '0) begin
                  errors++;
                  $display("FAIL idle_port %0d: err=%0b rdata=%h, required 0/0",
                           p, port_err(p), port_rdata(p));
               end
            end
         end
      end
   end

   task automatic check_order(input string name, input int base, input int n, input int fixed_n);
      checks++;
      if (done_log.size() - base != n) begin
         errors++;
         $display("FAIL %s_count: completions=%0d, required %0d", name, done_log.size() - base, n);
      end else begin
         for (int i = 0; i < n; i++) begin
            int want;
            want = (fixed_n > 0) ? ((i < fixed_n) ? 0 : 1) : (i % 2);
            checks++;
            if (done_log[base + i] != want) begin
               errors++;
               $display("FAIL %s[%0d]: port=%0d, required %0d", name, i, done_log[base + i], want);
            end
         end
      end
   endtask

   initial begin : main
      int base;
      rst_n     = 1'b0;
      mem_ready = 1'b1;
      drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      for (int w = 0; w < 256; w++) ref_mem[w] = '0;
      repeat (3) @(posedge clk);
      #2;
      check_quiet("reset_outputs");
      rst_n = 1'b1;

      // Known contents for both regions: words 0..15 for port 0, 16..31 for port 1
      for (int w = 0; w < 16; w++) begin
         access(0, 1'b1, 4'hF, 32'(w * 4), 32'h0, 1'b0);
         access(1, 1'b1, 4'hF, 32'((w + 16) * 4), 32'h0, 1'b0);
      end

      rst_n = 1'b0;
      @(posedge clk);
      #2;
      check_quiet("reset_again");
      rst_n = 1'b1;

      base = done_log.size();
`ifdef DATA_MEM_ARB_FIXED_PRIO_EN
      fork
         rep_reads(0, 10);
         rep_reads(1, 2);
      join
      check_order("fixed_prio", base, 12, 10);
`else
      fork
         rep_reads(0, 6);
         rep_reads(1, 6);
      join
      check_order("round_robin", base, 12, 0);
`endif

      access(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0);
      access(0, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0);

      access(1, 1'b1, 4'hF, 32'h50, 32'h0, 1'b0);
      access(1, 1'b1, 4'b0010, 32'h50, 32'h11223344, 1'b0);
      checks++;
      if (last_be != 4'b0010 || last_we != 1'b1) begin
         errors++;
         $display("FAIL be_passthru: be=%b we=%0b, required be=0010 we=1", last_be, last_we);
      end
      access(1, 1'b0, 4'hF, 32'h50, 32'h0, 1'b0);

      mem_ready = 1'b0;
      access(0, 1'b0, 4'hF, 32'h10, 32'h0, 1'b1);
      mem_ready = 1'b1;
      access(0, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0);

      // Abort an access with reset; no expectation is queued, so any ready pulse is flagged
      mem_ready = 1'b0;
      drive(0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
      repeat (3) @(posedge clk);
      #2;
      drive(1, 1'b1, 1'b0, 4'hF, 32'h50, 32'h0);
      rst_n = 1'b0;
      #1;
      check_quiet("reset_mid_busy");
      @(negedge clk);
      check_quiet("reset_held_with_req");
      drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      mem_ready = 1'b1;
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      base = done_log.size();
      fork
         access(0, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0);
         access(1, 1'b0, 4'hF, 32'h50, 32'h0, 1'b0);
      join
      check_order("post_reset_winner", base, 2, 1);

      fork
         rand_port(0, 40);
         rand_port(1, 40);
      join

      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
         errors++;
         $display("FAIL pending: outstanding=%0d/%0d, required 0/0", exp_q0.size(), exp_q1.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter that shares the single-port `data_mem` between the processor core LSU (port 0) and a secondary bus master such as DMA or a debug module (port 1). It serialises requests, drives the memory request interface for one access at a time, and routes the response back to the owning port. It sits between both masters and `data_mem` in the processor system top level.

## Interface

**Parameters**

- `TIMEOUT_CYCLES`, default 16: maximum BUSY cycles spent waiting for `ready_i` before the access is aborted with an error (≥1).

**Ports**

- `clk_i` input 1: clock; all state changes on the rising edge.
- `rst_ni` input 1: reset, asynchronous, active-low.
- `m0_req_i`, `m1_req_i` input 1: port request, held until that port's `mN_ready_o`.
- `m0_we_i`, `m1_we_i` input 1: 1 = write, 0 = read.
- `m0_be_i`, `m1_be_i` input 4: byte enables, used for writes only.
- `m0_addr_i`, `m1_addr_i` input 32: byte address.
- `m0_wdata_i`, `m1_wdata_i` input 32: write data.
- `m0_rdata_o`, `m1_rdata_o` output 32: read data, valid while `mN_ready_o` = 1 and `mN_we_i` was 0.
- `m0_ready_o`, `m1_ready_o` output 1: one-cycle completion pulse.
- `m0_err_o`, `m1_err_o` output 1: qualifies `mN_ready_o`; 1 = access timed out.
- `mem_req_o` output 1: request to `data_mem`.
- `write_enable_o` output 1: to `data_mem`.
- `byte_enable_o` output 4: to `data_mem`.
- `addr_o` output 32: to `data_mem`.
- `write_data_o` output 32: to `data_mem`.
- `read_data_i` input 32: from `data_mem`; valid the cycle after the request.
- `ready_i` input 1: from `data_mem`; response valid.

## Operation

**FSM states:** IDLE, BUSY.

**IDLE**
- If any `mN_req_i` = 1, select a winner:
  - One requester: that port wins.
  - Both requesters: the port indicated by the priority pointer wins.
- In the same cycle, drive `mem_req_o` = 1 and copy the winner's `we`, `be`, `addr` and `wdata` to the memory outputs combinationally.
- Register owner = winner, clear the wait counter, go to BUSY.
- No request: `mem_req_o` = 0, stay in IDLE.

**BUSY**
- `mem_req_o` = 0; the memory outputs hold the registered owner's last values.
- If `ready_i` = 1:
  - Owner `mN_ready_o` = 1 and `mN_rdata_o` = `read_data_i` combinationally.
  - The other port's `ready_o` = 0.
  - Priority pointer ← the non-owner port.
  - Go to IDLE.
- Else if the wait counter = `TIMEOUT_CYCLES`−1:
  - Owner `ready_o` = 1, `err_o` = 1, `rdata` = 0.
  - Pointer ← non-owner port.
  - Go to IDLE.
- Otherwise increment the wait counter.

**General rules**
- At most one outstanding access. Peak throughput is one access per two cycles.
- A non-owner port's `rdata_o` is 0 and its `ready_o`/`err_o` are 0.
- A requester that drops `req` before its `ready_o` is a protocol violation. Its access still completes and its response is discarded by the master.
- The wait counter is $clog2(`TIMEOUT_CYCLES`+1) bits wide and saturates. It never wraps.

## Timing

**Reset**
- State = IDLE, pointer = port 0, owner = 0, counter = 0.
- All outputs 0: `mem_req_o`, `write_enable_o`, `byte_enable_o`, `addr_o`, `write_data_o`, and every `mN_rdata_o`, `mN_ready_o`, `mN_err_o`.
- Reset asserted mid-BUSY aborts the access with no `ready_o`. The master re-issues after reset.

**Latency**
- With `ready_i` tied 1 (as `data_mem` provides), the request is granted at edge k and `ready_o` is high in cycle k+1.
- The next grant can occur at cycle k+2.

**Simultaneous events**
- A request arriving in the same cycle as another port's `ready_o` is arbitrated in the following IDLE cycle. The pointer update is already visible there.

**Writes**
- `data_mem` commits at the grant edge, so the written word is readable by any port from the next grant.

## Configuration

- `DATA_MEM_ARB_FIXED_PRIO_EN` defined: the priority pointer is removed and port 0 always wins on contention. Port 1 can be starved.
- Not defined: round-robin as described above. The port that did not own the previous access wins on contention.

## Test plan

- **Single write then read (port 0):** write `addr` 0x10, `wdata` 0xDEADBEEF, `be` 4'hF, then read 0x10 → `m0_ready_o` one cycle after each grant, `m0_rdata_o` = 0xDEADBEEF, `m0_err_o` = 0.
- **Contention after reset:** both ports request reads continuously → grants alternate 0,1,0,1. Each port sees `ready_o` every 4 cycles, and `m1_ready_o` is never high together with `m0_ready_o`.
- **Byte-enable pass-through:** port 1 writes 0x11223344 with `be` 4'b0010 to a word pre-set to 0 → a subsequent read returns 0x00003300. `byte_enable_o` = 4'b0010 at the grant.
- **Timeout:** `ready_i` forced 0, `TIMEOUT_CYCLES` = 16, port 0 read → `m0_ready_o` = 1 with `m0_err_o` = 1 and `rdata` 0 exactly 16 cycles after the grant, then the FSM returns to IDLE.
- **Reset mid-access:** `rst_ni` low during BUSY → all outputs 0 immediately, no `ready_o` pulse. After release, a port 1 request wins under contention with port 0 only if round-robin already pointed to 1; since the pointer resets to 0, port 0 wins.
- **Fixed priority (macro defined):** both ports request continuously for 20 cycles → every grant goes to port 0 and `m1_ready_o` stays 0.
